// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA raster iterator.
//   - 640x480@60 default timing constants
//   - whole_size(): total positions of a line or frame (visible + porches + sync)
//   - run_state_t: RUN / HOLD state of the optional single-frame hold mode
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE     = 640;
    localparam int unsigned DEF_H_FRONT_PORCH = 16;
    localparam int unsigned DEF_H_SYNC_PULSE  = 96;
    localparam int unsigned DEF_H_BACK_PORCH  = 48;
    localparam int unsigned DEF_V_VISIBLE     = 480;
    localparam int unsigned DEF_V_FRONT_PORCH = 10;
    localparam int unsigned DEF_V_SYNC_PULSE  = 2;
    localparam int unsigned DEF_V_BACK_PORCH  = 33;

    // Total raster length of one axis.
    function automatic int unsigned whole_size(
        input int unsigned visible,
        input int unsigned front_porch,
        input int unsigned sync_pulse,
        input int unsigned back_porch
    );
        return visible + front_porch + sync_pulse + back_porch;
    endfunction

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } run_state_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH x WIDTH shift register with synchronous reset value.
// DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, loads RESET_VAL into every stage
//   din   - data into the first stage
//   dout  - data delayed by DEPTH clocks
module vga_sync_delay #(
    parameter int unsigned       DEPTH     = 2,
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // clk/reset are not needed when there is nothing to delay
            logic unused_bypass;
            assign unused_bypass = ^{clk, reset};
            assign dout          = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_iter.sv
// vga_timing_iter: walks the full VGA raster (visible + porches + sync) one
// position per inc, producing registered x/y, wrap flags, visible, hsync and
// vsync aligned with x/y, plus a copy of visible/hsync/vsync delayed by
// PIPELINE_STAGES clocks for a downstream pixel pipeline.
//
// Optional build macro VGA_TIMING_ITER_FRAME_HOLD_EN: adds a start input and a
// RUN/HOLD mode; after reset or after each frame the raster parks at (0,0) with
// visible low and syncs inactive until start is seen.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   inc                  - advance one raster position this cycle
//   start                - (hold build only) leave HOLD and run one frame
//   x, y                 - current column / line
//   x_last, y_last       - x/y at the final column / line
//   visible              - x/y inside the visible area
//   hsync, vsync         - sync outputs at the configured polarity
//   visible_d/hsync_d/vsync_d - the above delayed PIPELINE_STAGES clocks
//   frame_done           - one-cycle pulse after the frame wraps
module vga_timing_iter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_PULSE    = DEF_H_SYNC_PULSE,
    parameter int unsigned H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_PULSE    = DEF_V_SYNC_PULSE,
    parameter int unsigned V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int unsigned H_SYNC_POL      = 0,
    parameter int unsigned V_SYNC_POL      = 0,
    parameter int unsigned PIPELINE_STAGES = 2,
    localparam int unsigned H_WHOLE_LINE   =
        whole_size(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
    localparam int unsigned V_WHOLE_FRAME  =
        whole_size(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
    localparam int unsigned X_BITS         = $clog2(H_WHOLE_LINE),
    localparam int unsigned Y_BITS         = $clog2(V_WHOLE_FRAME)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
    input  logic              start,
`endif
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              x_last,
    output logic              y_last,
    output logic              visible,
    output logic              hsync,
    output logic              vsync,
    output logic              visible_d,
    output logic              hsync_d,
    output logic              vsync_d,
    output logic              frame_done
);

    localparam logic [X_BITS-1:0] X_MAX    = X_BITS'(H_WHOLE_LINE - 1);
    localparam logic [Y_BITS-1:0] Y_MAX    = Y_BITS'(V_WHOLE_FRAME - 1);
    localparam logic [X_BITS-1:0] X_VIS    = X_BITS'(H_VISIBLE);
    localparam logic [Y_BITS-1:0] Y_VIS    = Y_BITS'(V_VISIBLE);
    localparam logic [X_BITS-1:0] HS_START = X_BITS'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [X_BITS-1:0] HS_END   =
        X_BITS'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [Y_BITS-1:0] VS_START = Y_BITS'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [Y_BITS-1:0] VS_END   =
        Y_BITS'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE - 1);
    localparam logic              HS_ACT   = 1'(H_SYNC_POL);
    localparam logic              VS_ACT   = 1'(V_SYNC_POL);

    logic              advance;
    logic              active_next;
    logic              wrap;
    logic [X_BITS-1:0] x_next;
    logic [Y_BITS-1:0] y_next;
    logic              visible_next;
    logic              hsync_next;
    logic              vsync_next;

`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
    localparam logic VIS_RST = 1'b0;

    run_state_t state;
    run_state_t state_next;

    // Counting only happens while a frame is being run.
    assign advance = inc && (state == RUN);

    // HOLD leaves on start; RUN returns to HOLD on wrap (start ignored in RUN).
    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (start) state_next = RUN;
            RUN:     if (wrap)  state_next = HOLD;
            default: state_next = HOLD;
        endcase
    end

    assign active_next = (state_next == RUN);
`else
    localparam logic VIS_RST = 1'b1;

    assign advance     = inc;
    assign active_next = 1'b1;
`endif

    // Next raster position; flags are derived from it so they line up with x/y.
    always_comb begin
        x_next = x;
        y_next = y;
        wrap   = advance && (x == X_MAX) && (y == Y_MAX);
        if (advance) begin
            if (x == X_MAX) begin
                x_next = '0;
                y_next = (y == Y_MAX) ? '0 : y + Y_BITS'(1);
            end else begin
                x_next = x + X_BITS'(1);
            end
        end
        visible_next = active_next && (x_next < X_VIS) && (y_next < Y_VIS);
        hsync_next   = (active_next && (x_next >= HS_START) && (x_next <= HS_END))
                       ? HS_ACT : ~HS_ACT;
        vsync_next   = (active_next && (y_next >= VS_START) && (y_next <= VS_END))
                       ? VS_ACT : ~VS_ACT;
    end

    // Position, flag and mode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            x_last     <= 1'b0;
            y_last     <= 1'b0;
            visible    <= VIS_RST;
            hsync      <= ~HS_ACT;
            vsync      <= ~VS_ACT;
            frame_done <= 1'b0;
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
            state      <= HOLD;
`endif
        end else begin
            x          <= x_next;
            y          <= y_next;
            x_last     <= (x_next == X_MAX);
            y_last     <= (y_next == Y_MAX);
            visible    <= visible_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            frame_done <= wrap;
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
            state      <= state_next;
`endif
        end
    end

    // Clock-based delay of the display flags; flushes to the inactive levels.
    vga_sync_delay #(
        .DEPTH     (PIPELINE_STAGES),
        .WIDTH     (3),
        .RESET_VAL ({1'b0, ~HS_ACT, ~VS_ACT})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({visible, hsync, vsync}),
        .dout  ({visible_d, hsync_d, vsync_d})
    );

endmodule

// File: tb/tb_vga_timing_iter.sv
// tb_vga_timing_iter: directed self-checking bench.
//   dut_a: default 640x480 timing, PIPELINE_STAGES = 2 (line-level checks,
//          delay alignment, mid-frame reset).
//   dut_b: tiny 14x9 raster, active-high hsync, PIPELINE_STAGES = 0
//          (frame-level checks: vsync window, wrap, frame_done).
// Honors VGA_TIMING_ITER_FRAME_HOLD_EN for the hold-mode build.
module tb_vga_timing_iter;

`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic VIS_RST = HOLD_EN ? 1'b0 : 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, inc_a;
    logic [9:0] x_a, y_a;
    logic       x_last_a, y_last_a, visible_a, hsync_a, vsync_a;
    logic       visible_d_a, hsync_d_a, vsync_d_a, frame_done_a;

    logic       reset_b, inc_b;
    logic [3:0] x_b, y_b;
    logic       x_last_b, y_last_b, visible_b, hsync_b, vsync_b;
    logic       visible_d_b, hsync_d_b, vsync_d_b, frame_done_b;

`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
    logic start_a, start_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_iter dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .inc        (inc_a),
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
        .start      (start_a),
`endif
        .x          (x_a),
        .y          (y_a),
        .x_last     (x_last_a),
        .y_last     (y_last_a),
        .visible    (visible_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .visible_d  (visible_d_a),
        .hsync_d    (hsync_d_a),
        .vsync_d    (vsync_d_a),
        .frame_done (frame_done_a)
    );

    vga_timing_iter #(
        .H_VISIBLE       (8),
        .H_FRONT_PORCH   (2),
        .H_SYNC_PULSE    (3),
        .H_BACK_PORCH    (1),
        .V_VISIBLE       (5),
        .V_FRONT_PORCH   (1),
        .V_SYNC_PULSE    (2),
        .V_BACK_PORCH    (1),
        .H_SYNC_POL      (1),
        .V_SYNC_POL      (0),
        .PIPELINE_STAGES (0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .inc        (inc_b),
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
        .start      (start_b),
`endif
        .x          (x_b),
        .y          (y_b),
        .x_last     (x_last_b),
        .y_last     (y_last_b),
        .visible    (visible_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .visible_d  (visible_d_b),
        .hsync_d    (hsync_d_b),
        .vsync_d    (vsync_d_b),
        .frame_done (frame_done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; returns 1 time unit after the last rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_start(input logic sa, input logic sb);
`ifdef VGA_TIMING_ITER_FRAME_HOLD_EN
        start_a = sa;
        start_b = sb;
`else
        if (sa || sb) $display("[TB] start ignored in this build");
`endif
    endtask

    initial begin
        reset_a = 1'b1;
        inc_a   = 1'b1;
        reset_b = 1'b1;
        inc_b   = 1'b1;
        drive_start(1'b0, 1'b0);

        // ---------------- dut_a: reset values ----------------
        step(2);
        check("a_rst_x",       32'(x_a), 0);
        check("a_rst_y",       32'(y_a), 0);
        check("a_rst_visible", 32'(visible_a), 32'(VIS_RST));
        check("a_rst_hsync",   32'(hsync_a), 1);
        check("a_rst_vsync",   32'(vsync_a), 1);
        check("a_rst_x_last",  32'(x_last_a), 0);
        check("a_rst_y_last",  32'(y_last_a), 0);
        check("a_rst_fdone",   32'(frame_done_a), 0);
        check("a_rst_vis_d",   32'(visible_d_a), 0);
        check("a_rst_hs_d",    32'(hsync_d_a), 1);
        check("a_rst_vs_d",    32'(vsync_d_a), 1);

        // release with inc low (start pulse in hold build)
        reset_a = 1'b0;
        inc_a   = 1'b0;
        drive_start(1'b1, 1'b0);
        step(1);
        check("a_rel_x",       32'(x_a), 0);
        check("a_rel_visible", 32'(visible_a), 1);
        drive_start(1'b0, 1'b0);
        inc_a = 1'b1;
        step(1);
        check("a_first_inc_x", 32'(x_a), 1);

        // half-rate inc
        for (int i = 0; i < 4; i++) begin
            inc_a = 1'b0;
            step(1);
            check("a_half_hold_x", 32'(x_a), 32'(1 + i));
            inc_a = 1'b1;
            step(1);
            check("a_half_inc_x", 32'(x_a), 32'(2 + i));
        end

        // horizontal timing on line 0
        step(634);
        check("a_x639",     32'(x_a), 639);
        check("a_vis_639",  32'(visible_a), 1);
        step(1);
        check("a_vis_640",  32'(visible_a), 0);
        step(15);
        check("a_hs_655",   32'(hsync_a), 1);
        step(1);
        check("a_x656",     32'(x_a), 656);
        check("a_hs_656",   32'(hsync_a), 0);
        check("a_hsd_656",  32'(hsync_d_a), 1);
        step(1);
        check("a_hsd_657",  32'(hsync_d_a), 1);
        step(1);
        check("a_hsd_658",  32'(hsync_d_a), 0);
        step(93);
        check("a_hs_751",   32'(hsync_a), 0);
        step(1);
        check("a_hs_752",   32'(hsync_a), 1);
        check("a_hsd_752",  32'(hsync_d_a), 0);
        step(47);
        check("a_x799",      32'(x_a), 799);
        check("a_xlast_799", 32'(x_last_a), 1);
        check("a_ylast_799", 32'(y_last_a), 0);
        step(1);
        check("a_wrap_x",     32'(x_a), 0);
        check("a_wrap_y",     32'(y_a), 1);
        check("a_wrap_xlast", 32'(x_last_a), 0);
        check("a_wrap_vis",   32'(visible_a), 1);

        // mid-frame reset at (300,1)
        step(300);
        check("a_x300", 32'(x_a), 300);
        reset_a = 1'b1;
        step(1);
        check("a_mrst_x",     32'(x_a), 0);
        check("a_mrst_y",     32'(y_a), 0);
        check("a_mrst_vis_d", 32'(visible_d_a), 0);
        check("a_mrst_hs_d",  32'(hsync_d_a), 1);
        check("a_mrst_vs_d",  32'(vsync_d_a), 1);
        reset_a = 1'b0;
        inc_a   = 1'b0;
        step(1);
        check("a_mrst1_x",     32'(x_a), 0);
        check("a_mrst1_vis_d", 32'(visible_d_a), 0);
        check("a_mrst1_hs_d",  32'(hsync_d_a), 1);
        step(1);
        check("a_mrst2_vis_d", 32'(visible_d_a), 32'(VIS_RST));

        // ---------------- dut_b: tiny raster ----------------
        check("b_rst_x",       32'(x_b), 0);
        check("b_rst_visible", 32'(visible_b), 32'(VIS_RST));
        check("b_rst_hsync",   32'(hsync_b), 0);
        check("b_rst_vsync",   32'(vsync_b), 1);
        check("b_rst_hs_d",    32'(hsync_d_b), 0);
        check("b_rst_vis_d",   32'(visible_d_b), 32'(VIS_RST));
        reset_b = 1'b0;
        if (HOLD_EN) begin
            inc_b = 1'b1;
            step(10);
            check("b_hold_x",   32'(x_b), 0);
            check("b_hold_vis", 32'(visible_b), 0);
            check("b_hold_hs",  32'(hsync_b), 0);
        end
        inc_b = 1'b0;
        drive_start(1'b0, 1'b1);
        step(1);
        drive_start(1'b0, 1'b0);
        check("b_run_x",   32'(x_b), 0);
        check("b_run_y",   32'(y_b), 0);
        check("b_run_vis", 32'(visible_b), 1);

        inc_b = 1'b1;
        step(7);
        check("b_vis_7",    32'(visible_b), 1);
        step(1);
        check("b_vis_8",    32'(visible_b), 0);
        step(2);
        check("b_x10",      32'(x_b), 10);
        check("b_hs_10",    32'(hsync_b), 1);
        check("b_hsd_10",   32'(hsync_d_b), 1);
        step(2);
        check("b_hs_12",    32'(hsync_b), 1);
        step(1);
        check("b_hs_13",    32'(hsync_b), 0);
        check("b_xlast_13", 32'(x_last_b), 1);
        check("b_ylast_13", 32'(y_last_b), 0);
        step(1);
        check("b_l1_x",     32'(x_b), 0);
        check("b_l1_y",     32'(y_b), 1);
        check("b_l1_xlast", 32'(x_last_b), 0);
        step(69);
        check("b_y5_x",     32'(x_b), 13);
        check("b_y5_y",     32'(y_b), 5);
        check("b_vs_5",     32'(vsync_b), 1);
        step(1);
        check("b_vs_6",     32'(vsync_b), 0);
        check("b_vsd_6",    32'(vsync_d_b), 0);
        step(14);
        check("b_vs_7",     32'(vsync_b), 0);
        step(14);
        check("b_vs_8",     32'(vsync_b), 1);
        check("b_ylast_8",  32'(y_last_b), 1);
        check("b_xlast_0_8", 32'(x_last_b), 0);
        step(13);
        check("b_end_x",     32'(x_b), 13);
        check("b_end_y",     32'(y_b), 8);
        check("b_end_xlast", 32'(x_last_b), 1);
        check("b_end_ylast", 32'(y_last_b), 1);
        check("b_end_fdone", 32'(frame_done_b), 0);
        drive_start(1'b0, 1'b1);
        step(1);
        drive_start(1'b0, 1'b0);
        check("b_wrap_x",     32'(x_b), 0);
        check("b_wrap_y",     32'(y_b), 0);
        check("b_wrap_fdone", 32'(frame_done_b), 1);
        check("b_wrap_ylast", 32'(y_last_b), 0);
        check("b_wrap_vis",   32'(visible_b), 32'(VIS_RST));
        inc_b = 1'b0;
        step(1);
        check("b_post_fdone", 32'(frame_done_b), 0);
        check("b_post_x",     32'(x_b), 0);
        inc_b = 1'b1;
        step(3);
        check("b_after_x",     32'(x_b), HOLD_EN ? 0 : 3);
        check("b_after_fdone", 32'(frame_done_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_iter.md
Name: vga_timing_iter

Overview:
- Parametrised successor to the plain x/y pixel iterator.
- Walks the full VGA raster (visible area plus porches) one position per `inc`.
- Generates registered hsync, vsync and visible flags aligned with x/y, plus copies delayed by a fixed number of clocks to line up with a downstream pixel pipeline.
- Sits between the pixel clock domain and the framebuffer read / DAC output stage.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_VISIBLE, 480, visible lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- PIPELINE_STAGES, 2, clock delay applied to the *_d outputs (0 allowed)
- Derived: H_WHOLE_LINE = sum of H_*; V_WHOLE_FRAME = sum of V_*; X_BITS = $clog2(H_WHOLE_LINE); Y_BITS = $clog2(V_WHOLE_FRAME)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inc  in  1  advance one raster position this cycle
- x  out  X_BITS  current column
- y  out  Y_BITS  current line
- x_last  out  1  x == H_WHOLE_LINE-1
- y_last  out  1  y == V_WHOLE_FRAME-1
- visible  out  1  x < H_VISIBLE && y < V_VISIBLE
- hsync  out  1  aligned with x/y
- vsync  out  1  aligned with x/y
- visible_d, hsync_d, vsync_d  out  1 each  above signals delayed PIPELINE_STAGES clocks
- frame_done  out  1  one-cycle pulse on wrap (x_last && y_last && inc)

Behaviour:
- Reset values:
  - x = 0, y = 0, visible = 1, x_last = 0, y_last = 0, frame_done = 0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - Every delay stage: visible_d = 0, syncs at their inactive level.
- inc = 0: all counters and flags hold. Delay pipeline still shifts every clock (clock-based delay, not inc-based).
- inc = 1:
  - x increments.
  - At x == H_WHOLE_LINE-1: x → 0 and y increments.
  - At y == V_WHOLE_FRAME-1 with x wrap: y → 0 and frame_done pulses the next cycle.
- Flag registers are computed from the next x/y, so they are valid in the same cycle as the x/y they describe. Latency from inc to new x/y/flags is 1 clock.
- Sync windows:
  - hsync active for x in [H_VISIBLE+H_FRONT_PORCH, H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE-1]; defaults 656..751.
  - vsync active for y in [V_VISIBLE+V_FRONT_PORCH, V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE-1]; defaults 490..491.
- x_last and y_last are independent; both high only at the final position.
- PIPELINE_STAGES = 0: *_d outputs are wires equal to the undelayed signals.
- Reset mid-frame: next cycle returns to the reset values; the delay pipeline is flushed to its inactive values.
- All arithmetic uses unsigned compares at X_BITS/Y_BITS widths; no overflow is reachable.

Optional Feature:
- Macro: VGA_TIMING_ITER_FRAME_HOLD_EN.
- With the macro:
  - Adds input port `start` (1 bit).
  - Two-state FSM, RUN / HOLD. Reset enters HOLD.
  - HOLD: x = y = 0; visible forced 0; syncs inactive; inc ignored.
  - HOLD → RUN on the clock where start = 1. x/y remain 0 that cycle; the first advance happens on the next inc.
  - RUN → HOLD on wrap. frame_done still pulses.
  - start in RUN is ignored, including when simultaneous with the wrap.
- Without the macro: no start port; always RUN; free-running.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 default constants.
  - A helper function computing the whole-line and whole-frame sizes.
  - The FSM state enum (RUN, HOLD).
- Sub-module vga_sync_delay: parametrised depth (≥0) × width shift register with synchronous reset value; used for the *_d bundle.

Test Plan:
- Reset held 2 clocks, inc = 1 → x = 0, y = 0, visible = 1, hsync = vsync = 1. One clock after reset release → x = 0; next clock → x = 1.
- Free-run → hsync falls when x = 656, rises at x = 752. At x = 799: x_last = 1, then x = 0, y = 1. visible = 0 at x = 640.
- Run to y = 490 → vsync low for lines 490–491 only. At (799,524) next is (0,0) with a one-cycle frame_done pulse.
- Toggle inc every other clock → x advances at half rate; hsync_d matches hsync exactly 2 clocks later (PIPELINE_STAGES = 2); PIPELINE_STAGES = 0 build → equal same cycle.
- Assert reset at (300,200) → next cycle (0,0) and all *_d outputs inactive for 2 clocks.
- FRAME_HOLD_EN build: after reset, inc = 1 for 10 clocks → x stays 0, visible = 0. Pulse start → RUN, x = 1 after the next inc cycle. After a full frame → back in HOLD at (0,0) with one frame_done pulse.
